seq_divider: RTL
================

Name: seq_divider

Overview:
- Iterative radix-2 restoring divider. It is the inverse-operation companion to the Booth/Wallace multiplier datapath.
- Accepts a WIDTH-bit dividend and divisor over a valid/ready handshake.
- Produces one quotient bit per cycle using a single WIDTH+1-bit trial subtractor.
- Returns the quotient, the remainder and a divide-by-zero flag over a second valid/ready handshake. Sits beside the multiplier in the arithmetic unit.

Parameters:
- WIDTH, 64, operand, quotient and remainder width in bits (must be ≥ 2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  divider can accept operands.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  set with the result when divisor was 0.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- A reset asserted mid-operation aborts the division; no result is emitted.
- States are IDLE, BUSY, DONE.
- IDLE: in_ready=1, out_valid=0.
  - On an edge with in_valid=1, operands are latched (accept edge E0).
  - If divisor==0, go to DONE at E0 with quotient = all ones, remainder = dividend, div_by_zero=1.
  - Otherwise go to BUSY with partial remainder R=0, Q=dividend, counter=0.
- BUSY: in_ready=0, out_valid=0. Each edge performs one iteration:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} − {1'b0, divisor}, computed at WIDTH+1 bits.
  - If T is non-negative (MSB=0): R=T[WIDTH-1:0] and the quotient bit is 1.
  - Otherwise: R={R[WIDTH-2:0], Q[WIDTH-1]} (restore) and the quotient bit is 0.
  - Q shifts left, inserting the quotient bit at the LSB. Counter increments.
  - The edge completing iteration WIDTH (counter==WIDTH-1) moves to DONE.
  - quotient and remainder registers load on that same edge; div_by_zero=0.
- Latency: out_valid rises after edge E_WIDTH, i.e. WIDTH cycles after the accept edge. The divide-by-zero path takes 1 cycle.
- DONE: out_valid=1, in_ready=0. Outputs are held stable until out_ready=1.
  - On that edge, go to IDLE; out_valid=0 the following cycle.
  - Outputs keep their last values after the handshake; the consumer ignores them when out_valid=0.
- No new operand is accepted in DONE or BUSY. in_valid is ignored there, and the operand inputs may change freely outside IDLE.
- Throughput: one division per WIDTH+2 cycles, with out_ready held high.
- out_ready asserted while out_valid=0 has no effect.
- dividend < divisor yields quotient=0 and remainder=dividend.
- divisor==1 yields quotient=dividend and remainder=0.
- Invariant for divisor≠0: quotient*divisor + remainder == dividend, and remainder < divisor.

Optional Feature:
- Macro SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Adds input port op_signed (1 bit, sampled at the accept edge).
  - When op_signed=1, the operands are two's complement. Magnitudes are divided on the unsigned core.
  - The quotient is truncated toward zero (negated if the operand signs differ). The remainder takes the dividend's sign.
  - Signs are applied on the edge that loads the result, so latency is unchanged.
  - Overflow case (most negative value / −1): quotient = most negative value, remainder=0, div_by_zero=0.
  - Signed divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1.
- Undefined: the op_signed port does not exist and all operands are unsigned.

Test Plan:
- Reset then idle: rst for 2 cycles -> in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
- Basic division: dividend=100, divisor=7, out_ready=1 -> out_valid exactly 64 cycles after the accept edge, with quotient=14, remainder=2, div_by_zero=0. in_ready=0 throughout BUSY/DONE.
- Divide by zero: dividend=0x1234, divisor=0 -> out_valid 1 cycle after accept, quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234, div_by_zero=1.
- Boundary operands:
  - 0xFFFF_FFFF_FFFF_FFFF / 1 -> quotient=all ones, remainder=0.
  - 5 / 9 -> quotient=0, remainder=5.
  - 0xFFFF_FFFF_FFFF_FFFF / 0xFFFF_FFFF_FFFF_FFFF -> quotient=1, remainder=0.
- Backpressure and abort:
  - Hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_valid ignored. Release -> IDLE next cycle.
  - Assert rst mid-BUSY (iteration 30) -> IDLE next cycle, no out_valid.
- With SEQ_DIVIDER_SIGNED_EN defined:
  - op_signed=1, −7 / 2 -> quotient=−3, remainder=−1.
  - op_signed=1, 0x8000_0000_0000_0000 / −1 -> quotient=0x8000_0000_0000_0000, remainder=0.

Source files
------------

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_divider                                                     |
// | Purpose  : Iterative radix-2 restoring divider, one quotient bit per cycle, |
// |            valid/ready in and out. SEQ_DIVIDER_SIGNED_EN adds op_signed.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_divider #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             op_signed,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;
    logic             r_dbz;

    logic             w_op_signed;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_quot_final;
    logic [WIDTH-1:0] w_rem_final;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign w_op_signed = op_signed;
`else
    assign w_op_signed = 1'b0;
`endif

    // Negating the most negative value yields 2^(WIDTH-1), the correct magnitude.
    assign w_dvd_mag = (w_op_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dvs_mag = (w_op_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    assign w_trial    = {r_rem, r_q[WIDTH-1]} - {1'b0, r_dvs};
    assign w_qbit     = ~w_trial[WIDTH];
    assign w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_q_next   = {r_q[WIDTH-2:0], w_qbit};

    assign w_quot_final = r_neg_q ? -w_q_next   : w_q_next;
    assign w_rem_final  = r_neg_r ? -w_rem_next : w_rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_remd      <= '0;
            r_dbz       <= 1'b0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (divisor == '0) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_quot      <= '1;
                            r_remd      <= dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state <= S_BUSY;
                            r_rem   <= '0;
                            r_q     <= w_dvd_mag;
                            r_dvs   <= w_dvs_mag;
                            r_cnt   <= '0;
                            r_neg_q <= w_op_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_neg_r <= w_op_signed & dividend[WIDTH-1];
                        end
                    end
                end
                S_BUSY: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    // Signs are applied on the loading edge so latency matches unsigned.
                    if (r_cnt == c_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_quot      <= w_quot_final;
                        r_remd      <= w_rem_final;
                        r_dbz       <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quot;
    assign remainder   = r_remd;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
